// File: rtl/quadrado_pkg.sv
// Shared types and constants for the quadrado shift-and-add squarer.
package quadrado_pkg;

    localparam int QUAD_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/quadrado_adder.sv
// Ripple-carry adder used as the squarer's accumulation stage.
module adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] carry;

    assign carry[0] = cin_i;

    for (genvar k = 0; k < W; k++) begin : g_bit
        assign sum_o[k] = a_i[k] ^ b_i[k] ^ carry[k];
        // The top carry-out is never needed: the accumulator cannot overflow.
        if (k < W - 1) begin : g_carry
            assign carry[k+1] = (a_i[k] & b_i[k]) | (carry[k] & (a_i[k] ^ b_i[k]));
        end
    end

endmodule

// File: rtl/quadrado.sv
// Sequential squarer: computes data_in*data_in by shift-and-add over n CALC cycles.
module quadrado
    import quadrado_pkg::*;
#(
    parameter int n = QUAD_DEFAULT_N
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [n-1:0]   data_in,
    input  logic           start,
    output logic [2*n-1:0] data_out,
    output logic           busy,
    output logic           done,
    output logic [31:0]    cycles
);

    localparam int            IW     = (n > 1) ? $clog2(n) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(n - 1);

    state_t          state_q;
    logic [n-1:0]    x_q;
    logic [n-1:0]    m_q;
    logic [n-1:0]    m_d;
    logic [2*n-1:0]  acc_q;
    logic [2*n-1:0]  acc_d;
    logic [2*n-1:0]  addend;
    logic [IW-1:0]   i_q;
    logic [IW-1:0]   i_d;
    logic [2*n-1:0]  dout_q;
    logic            busy_q;
    logic            done_q;
    logic [31:0]     cyc_q;
    logic [31:0]     cyc_d;

    // Partial product for this iteration: X weighted by 2^i when the current multiplier bit is set.
    always_comb begin
        addend = '0;
        if (m_q[0]) begin
            addend = {{n{1'b0}}, x_q} << i_q;
        end
    end

    adder #(
        .W(2 * n)
    ) u_adder (
        .a_i   (acc_q),
        .b_i   (addend),
        .cin_i (1'b0),
        .sum_o (acc_d)
    );

    always_comb begin
        m_d   = m_q >> 1;
        i_d   = i_q + 1'b1;
        cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            cyc_q  <= cyc_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= data_in;
                        m_q     <= data_in;
                        acc_q   <= '0;
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    m_q   <= m_d;
                    i_q   <= i_d;
                    if (i_q == LAST_I) begin
                        dout_q  <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out = dout_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cycles   = cyc_q;

endmodule
